cnt_day_month: RTL and testbench

- Calendar day/month counter that sits directly upstream of the year counter.
- Counts day (01..last day of month) and month (01..12) in BCD.
- Advances on the day carry from the hour counter.
- Drives the year counter's carry input and reads the year BCD digits back for the leap-year decision.
- Also supports manual setting of either field through the same run/set mode inputs the other counters use.

---
 rtl/cnt_day_month_pkg.sv | 60 ++++++
 rtl/cnt_day_month_if.sv | 29 ++
 rtl/cal_month_len.sv | 22 ++
 rtl/cnt_day_month.sv | 79 +++++++
 tb/tb_cnt_day_month.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cnt_day_month_pkg.sv
// rtl/cnt_day_month_pkg.sv - calendar constants, mode encoding and BCD/leap helpers
`timescale 1ns/1ps
package cal_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_SET    = 2'b10,
        MODE_HOLD_B = 2'b11
    } mode_e;

    localparam logic [7:0] JAN = 8'h01;
    localparam logic [7:0] FEB = 8'h02;
    localparam logic [7:0] MAR = 8'h03;
    localparam logic [7:0] APR = 8'h04;
    localparam logic [7:0] MAY = 8'h05;
    localparam logic [7:0] JUN = 8'h06;
    localparam logic [7:0] JUL = 8'h07;
    localparam logic [7:0] AUG = 8'h08;
    localparam logic [7:0] SEP = 8'h09;
    localparam logic [7:0] OCT = 8'h10;
    localparam logic [7:0] NOV = 8'h11;
    localparam logic [7:0] DEC = 8'h12;

    localparam logic [7:0] DAY_FIRST = 8'h01;
    localparam logic [7:0] MON_LAST  = 8'h12;
    localparam logic [7:0] DAYS_28   = 8'h28;
    localparam logic [7:0] DAYS_29   = 8'h29;
    localparam logic [7:0] DAYS_30   = 8'h30;
    localparam logic [7:0] DAYS_31   = 8'h31;

    // Year range is 000..100; 100 is never leap, 000 depends on the calendar base.
    function automatic logic is_leap(input logic [3:0] ones, input logic [3:0] tens,
                                     input logic [3:0] hund, input logic base_leap);
        logic leap;
        if (hund != 4'd0)
            leap = 1'b0;
        else if (tens == 4'd0 && ones == 4'd0)
            leap = base_leap;
        else if (tens[0] == 1'b0)
            leap = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
        else
            leap = (ones == 4'd2) || (ones == 4'd6);
        return leap;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] >= 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
    endfunction

endpackage

// File: rtl/cnt_day_month_if.sv
// rtl/cnt_day_month_if.sv - control, year and date signals of the day/month counter
`timescale 1ns/1ps
interface cnt_day_month_if;
    logic       ENABLE;
    logic       CARRY_in;
    logic [1:0] SET_CURRENT_STATE;
    logic       INC_MODE;
    logic       SET_SEL;
    logic [3:0] YEAR_ONES;
    logic [3:0] YEAR_TENS;
    logic [3:0] YEAR_HUND;
    logic [3:0] DAY1;
    logic [3:0] DAY10;
    logic [3:0] MON1;
    logic [3:0] MON10;
    logic       CARRY_out;

    modport master (
        output ENABLE, CARRY_in, SET_CURRENT_STATE, INC_MODE, SET_SEL,
               YEAR_ONES, YEAR_TENS, YEAR_HUND,
        input  DAY1, DAY10, MON1, MON10, CARRY_out
    );

    modport slave (
        input  ENABLE, CARRY_in, SET_CURRENT_STATE, INC_MODE, SET_SEL,
               YEAR_ONES, YEAR_TENS, YEAR_HUND,
        output DAY1, DAY10, MON1, MON10, CARRY_out
    );
endinterface

// File: rtl/cal_month_len.sv
// rtl/cal_month_len.sv - last day of a BCD month, leap aware
`timescale 1ns/1ps
module cal_month_len
    import cal_pkg::*;
(
    input  logic [7:0] MON,
    input  logic       LEAP,
    output logic [7:0] LAST_DAY
);

    always_comb begin
        LAST_DAY = DAYS_31;
        case (MON)
            FEB:                     LAST_DAY = LEAP ? DAYS_29 : DAYS_28;
            APR, JUN, SEP, NOV:      LAST_DAY = DAYS_30;
            JAN, MAR, MAY, JUL,
            AUG, OCT, DEC:           LAST_DAY = DAYS_31;
            default:                 LAST_DAY = DAYS_31;
        endcase
    end

endmodule

// File: rtl/cnt_day_month.sv
// rtl/cnt_day_month.sv - BCD day/month calendar counter feeding the year counter
`timescale 1ns/1ps
module cnt_day_month
    import cal_pkg::*;
#(
    parameter bit BASE_LEAP = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    cnt_day_month_if.slave    bus
);

    logic [7:0] r_day;
    logic [7:0] r_mon;
    logic [7:0] w_day_nxt;
    logic [7:0] w_mon_nxt;
    logic [7:0] w_last_day;
    logic       w_leap;
    logic       w_run_tick;
    logic       w_set_inc;
    logic       w_day_bad;
    logic       w_mon_bad;
    mode_e      w_mode;

    assign w_mode     = mode_e'(bus.SET_CURRENT_STATE);
    assign w_leap     = is_leap(bus.YEAR_ONES, bus.YEAR_TENS, bus.YEAR_HUND, BASE_LEAP);
    assign w_run_tick = (w_mode == MODE_RUN) && bus.ENABLE && bus.CARRY_in;
    assign w_set_inc  = (w_mode == MODE_SET) && bus.INC_MODE;
    assign w_day_bad  = !bcd_valid(r_day) || (r_day == 8'h00);
    assign w_mon_bad  = !bcd_valid(r_mon) || (r_mon == 8'h00) || (r_mon > MON_LAST);

    cal_month_len u_month_len (
        .MON      (r_mon),
        .LEAP     (w_leap),
        .LAST_DAY (w_last_day)
    );

    // Recovery from corrupted digits wins; otherwise run tick, then set, then clamp.
    always_comb begin
        w_day_nxt = r_day;
        w_mon_nxt = r_mon;
        if (w_day_bad || w_mon_bad) begin
            if (w_day_bad) w_day_nxt = DAY_FIRST;
            if (w_mon_bad) w_mon_nxt = JAN;
        end else if (w_run_tick) begin
            if (r_day >= w_last_day) begin
                w_day_nxt = DAY_FIRST;
                w_mon_nxt = (r_mon == MON_LAST) ? JAN : bcd_inc(r_mon);
            end else begin
                w_day_nxt = bcd_inc(r_day);
            end
        end else if (w_set_inc) begin
            if (bus.SET_SEL)
                w_mon_nxt = (r_mon == MON_LAST) ? JAN : bcd_inc(r_mon);
            else
                w_day_nxt = (r_day >= w_last_day) ? DAY_FIRST : bcd_inc(r_day);
        end else if (r_day > w_last_day) begin
            w_day_nxt = w_last_day;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_day <= DAY_FIRST;
            r_mon <= JAN;
        end else begin
            r_day <= w_day_nxt;
            r_mon <= w_mon_nxt;
        end
    end

    // Same-cycle carry so the year counter advances on the wrap edge itself.
    assign bus.CARRY_out = RESET && w_run_tick && (r_mon == DEC) && (r_day == DAYS_31);
    assign bus.DAY1      = r_day[3:0];
    assign bus.DAY10     = r_day[7:4];
    assign bus.MON1      = r_mon[3:0];
    assign bus.MON10     = r_mon[7:4];

endmodule

// File: tb/tb_cnt_day_month.sv
// tb/tb_cnt_day_month.sv - directed and randomized check of cnt_day_month against a calendar model
`timescale 1ns/1ps
module tb_cnt_day_month;

    localparam bit BASE_LEAP = 1'b1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cnt_day_month_if bus ();

    cnt_day_month #(.BASE_LEAP(BASE_LEAP)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_day;
    int m_mon;
    int year;

    function automatic bit leap(input int y);
        if (y == 100) return 1'b0;
        if (y == 0)   return BASE_LEAP;
        return (y % 4) == 0;
    endfunction

    function automatic int month_days(input int m, input int y);
        case (m)
            2:             return leap(y) ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [15:0] dut_date();
        return {bus.MON10, bus.MON1, bus.DAY10, bus.DAY1};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_year(input int y);
        year = y;
        bus.YEAR_HUND = 4'(y / 100);
        bus.YEAR_TENS = 4'((y / 10) % 10);
        bus.YEAR_ONES = 4'(y % 10);
    endtask

    // Called at a falling edge: drive, check combinational carry, clock, check date.
    task automatic step(input logic [1:0] mode, input logic en, input logic cin,
                        input logic inc, input logic sel);
        bit   tick;
        int   last;
        logic exp_c;
        bus.SET_CURRENT_STATE = mode;
        bus.ENABLE   = en;
        bus.CARRY_in = cin;
        bus.INC_MODE = inc;
        bus.SET_SEL  = sel;
        tick  = (mode == 2'b01) && en && cin;
        last  = month_days(m_mon, year);
        exp_c = tick && (m_mon == 12) && (m_day == 31);
        #1;
        check("carry_out", {15'd0, bus.CARRY_out}, {15'd0, exp_c});
        if (tick) begin
            if (m_day >= last) begin
                m_day = 1;
                m_mon = (m_mon == 12) ? 1 : m_mon + 1;
            end else begin
                m_day++;
            end
        end else if (mode == 2'b10 && inc) begin
            if (sel) m_mon = (m_mon == 12) ? 1 : m_mon + 1;
            else     m_day = (m_day >= last) ? 1 : m_day + 1;
        end else if (m_day > last) begin
            m_day = last;
        end
        @(posedge clk);
        @(negedge clk);
        bus.INC_MODE = 1'b0;
        check("date", dut_date(), {to_bcd(m_mon), to_bcd(m_day)});
    endtask

    task automatic do_reset();
        bus.SET_CURRENT_STATE = 2'b00;
        bus.ENABLE   = 1'b0;
        bus.CARRY_in = 1'b0;
        bus.INC_MODE = 1'b0;
        bus.SET_SEL  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_day = 1;
        m_mon = 1;
    endtask

    task automatic set_date(input int d, input int m);
        do_reset();
        for (int i = 0; i < 16 && m_mon != m; i++) step(2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40 && m_day != d; i++) step(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        check("set_date", dut_date(), {to_bcd(m), to_bcd(d)});
    endtask

    task automatic tick();
        step(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.SET_CURRENT_STATE = 2'b00;
        bus.ENABLE   = 1'b0;
        bus.CARRY_in = 1'b0;
        bus.INC_MODE = 1'b0;
        bus.SET_SEL  = 1'b0;
        drive_year(23);
        repeat (2) @(negedge clk);
        check("reset_date", dut_date(), 16'h0101);
        check("reset_carry", {15'd0, bus.CARRY_out}, 16'd0);
        rst_n = 1'b1;
        m_day = 1;
        m_mon = 1;

        // Asynchronous reset in the middle of a clock phase.
        set_date(15, 7);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", dut_date(), 16'h0101);
        @(negedge clk);
        rst_n = 1'b1;
        m_day = 1;
        m_mon = 1;
        step(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        check("hold_after_reset", dut_date(), 16'h0101);

        set_date(31, 12);
        bus.SET_CURRENT_STATE = 2'b01;
        bus.ENABLE   = 1'b1;
        bus.CARRY_in = 1'b1;
        #1 check("carry_pre_reset", {15'd0, bus.CARRY_out}, 16'd1);
        rst_n = 1'b0;
        #1 check("carry_in_reset", {15'd0, bus.CARRY_out}, 16'd0);
        check("date_in_reset", dut_date(), 16'h0101);
        do_reset();

        // February across leap/non-leap years.
        drive_year(23);  set_date(28, 2); tick(); check("y023_feb28", dut_date(), 16'h0301);
        drive_year(24);  set_date(28, 2); tick(); check("y024_feb28", dut_date(), 16'h0229);
        tick();                                   check("y024_feb29", dut_date(), 16'h0301);
        drive_year(100); set_date(28, 2); tick(); check("y100_feb28", dut_date(), 16'h0301);
        drive_year(0);   set_date(28, 2); tick(); check("y000_feb28", dut_date(), 16'h0229);

        drive_year(23);
        set_date(30, 4); tick(); check("apr30", dut_date(), 16'h0501);
        set_date(31, 1); tick(); check("jan31", dut_date(), 16'h0201);
        set_date(9, 9);  tick(); check("sep09", dut_date(), 16'h0910);

        set_date(31, 12); tick(); check("dec31_wrap", dut_date(), 16'h0101);
        set_date(31, 12);
        step(2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        check("dec31_no_en", dut_date(), 16'h1231);

        // Month set from 01/31 exposes the one-cycle transient, then clamps.
        set_date(31, 1);
        step(2'b10, 1'b0, 1'b0, 1'b1, 1'b1); check("set_mon_transient", dut_date(), 16'h0231);
        step(2'b10, 1'b0, 1'b0, 1'b0, 1'b1); check("set_mon_clamp", dut_date(), 16'h0228);
        set_date(5, 12);
        step(2'b10, 1'b0, 1'b0, 1'b1, 1'b1); check("set_mon_wrap", dut_date(), 16'h0105);
        set_date(30, 4);
        step(2'b10, 1'b0, 1'b0, 1'b1, 1'b0); check("set_day_wrap", dut_date(), 16'h0401);

        set_date(17, 6);
        step(2'b11, 1'b1, 1'b1, 1'b1, 1'b0); check("hold_11", dut_date(), 16'h0617);
        step(2'b00, 1'b1, 1'b1, 1'b1, 1'b1); check("hold_00", dut_date(), 16'h0617);

        drive_year(24); set_date(29, 2);
        drive_year(25);
        step(2'b11, 1'b0, 1'b0, 1'b0, 1'b0); check("year_change_clamp", dut_date(), 16'h0228);

        // Random traffic, run ticks favoured so the calendar actually advances.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [1:0] mode;
            int r;
            r = int'($urandom_range(0, 9));
            mode = (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'(r - 8) ;
            if ($urandom_range(0, 49) == 0) drive_year(int'($urandom_range(0, 100)));
            step(mode, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
